// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter.
//   tx_state_e  : transmitter frame states
//   par_mode_e  : encoding of the par_mode input (11 behaves like none)
//   par_enabled : true when a parity bit is appended
//   calc_parity : parity bit value for a payload (zero-extended to MaxDataBits)
package uart_pkg;

  localparam int unsigned MaxDataBits = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  typedef enum logic [1:0] {
    ParNone  = 2'b00,
    ParEven  = 2'b01,
    ParOdd   = 2'b10,
    ParNone2 = 2'b11
  } par_mode_e;

  function automatic logic par_enabled(input par_mode_e mode);
    return (mode == ParEven) || (mode == ParOdd);
  endfunction

  // Zero-extension does not change the XOR, so one width serves every DATA_BITS.
  function automatic logic calc_parity(input logic [MaxDataBits-1:0] data,
                                       input par_mode_e mode);
    return (mode == ParOdd) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and an occupancy counter.
//   clk, rst : clock, asynchronous active-high reset
//   i_push   : write i_data (ignored when full)
//   i_pop    : advance read pointer (ignored when empty)
//   o_data   : word at the head (valid while !o_empty)
//   o_full, o_empty, o_level : occupancy status
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with a transmit FIFO and per-frame parity/stop configuration.
//   clk, rst   : clock, asynchronous active-high reset
//   baud_tick  : one-clk pulse per bit period
//   s_valid/s_ready/s_data : write port into the FIFO
//   par_mode, stop2        : frame format, sampled when a word is popped
//   tx         : serial line (idle high)
//   busy       : frame in progress
//   tx_done    : pulse when the final stop bit is driven
//   fifo_level : FIFO occupancy
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic [1:0]                    par_mode,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CW = $clog2(DATA_BITS);

  tx_state_e            r_state, w_state_d;
  logic [DATA_BITS-1:0] r_shift, w_shift_d;
  logic [CW-1:0]        r_bit_cnt, w_bit_cnt_d;
  logic                 r_par_en, w_par_en_d;
  logic                 r_par_bit, w_par_bit_d;
  logic                 r_stop2, w_stop2_d;
  logic                 r_stop_cnt, w_stop_cnt_d;
  logic                 r_tx, w_tx_d;
  logic                 r_done, w_done_d;

  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_fifo_data;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (s_valid),
    .i_pop   (w_pop),
    .i_data  (s_data),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_shift    <= w_shift_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_par_en   <= w_par_en_d;
      r_par_bit  <= w_par_bit_d;
      r_stop2    <= w_stop2_d;
      r_stop_cnt <= w_stop_cnt_d;
      r_tx       <= w_tx_d;
      r_done     <= w_done_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_shift_d    = r_shift;
    w_bit_cnt_d  = r_bit_cnt;
    w_par_en_d   = r_par_en;
    w_par_bit_d  = r_par_bit;
    w_stop2_d    = r_stop2;
    w_stop_cnt_d = r_stop_cnt;
    w_tx_d       = r_tx;
    w_done_d     = 1'b0;
    w_pop        = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_tx_d = 1'b1;
        if (!w_empty) begin
          // Format is frozen here; later par_mode/stop2 changes wait for the next pop.
          w_pop       = 1'b1;
          w_shift_d   = w_fifo_data;
          w_par_en_d  = par_enabled(par_mode_e'(par_mode));
          w_par_bit_d = calc_parity(MaxDataBits'(w_fifo_data), par_mode_e'(par_mode));
          w_stop2_d   = stop2;
          w_state_d   = StStart;
        end
      end
      StStart: begin
        if (baud_tick) begin
          w_tx_d      = 1'b0;
          w_bit_cnt_d = '0;
          w_state_d   = StData;
        end
      end
      StData: begin
        if (baud_tick) begin
          w_tx_d    = r_shift[0];
          w_shift_d = r_shift >> 1;
          if (r_bit_cnt == CW'(DATA_BITS - 1)) begin
            w_stop_cnt_d = 1'b0;
            w_state_d    = r_par_en ? StParity : StStop;
          end else begin
            w_bit_cnt_d = r_bit_cnt + CW'(1);
          end
        end
      end
      StParity: begin
        if (baud_tick) begin
          w_tx_d       = r_par_bit;
          w_stop_cnt_d = 1'b0;
          w_state_d    = StStop;
        end
      end
      StStop: begin
        if (baud_tick) begin
          w_tx_d = 1'b1;
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_cnt_d = 1'b1;
          end else begin
            // Returning to idle here means the next start bit waits a full tick.
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign s_ready = ~w_full;
  assign tx      = r_tx;
  assign busy    = (r_state != StIdle);
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
module tb_uart_tx_fifo_cfg;

  localparam int TICK_DIV = 4;

  typedef struct {
    logic [7:0] data;
    logic [1:0] par;
    logic       stop2;
    logic       exp_par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       tick_en;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [1:0] par_mode;
  logic       stop2;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [4:0] fifo_level;

  logic       baud_tick5;
  logic       s_valid5;
  logic       s_ready5;
  logic [4:0] s_data5;
  logic       tx5;
  logic       busy5;
  logic       tx_done5;
  logic [2:0] fifo_level5;

  int checks = 0;
  int errors = 0;

  vec_t exp_q[$];
  logic mon_active;
  int   mon_idx;
  int   mon_len;
  logic mon_bits[16];
  logic b2b_pending;
  int   frames_done;
  int   done_cnt;

  always #5 clk = ~clk;

  uart_tx_fifo_cfg #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .par_mode   (par_mode),
    .stop2      (stop2),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_level (fifo_level)
  );

  uart_tx_fifo_cfg #(
    .DATA_BITS  (5),
    .FIFO_DEPTH (4)
  ) u_dut5 (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick5),
    .s_valid    (s_valid5),
    .s_ready    (s_ready5),
    .s_data     (s_data5),
    .par_mode   (2'b00),
    .stop2      (1'b0),
    .tx         (tx5),
    .busy       (busy5),
    .tx_done    (tx_done5),
    .fifo_level (fifo_level5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Tick generator plus scoreboard monitor. The monitor runs first each negedge so
  // baud_tick still holds the value the DUT saw at the preceding posedge.
  initial begin
    vec_t e;
    int   div;
    int   p;
    baud_tick   = 1'b0;
    div         = 0;
    mon_active  = 1'b0;
    mon_idx     = 0;
    mon_len     = 0;
    b2b_pending = 1'b0;
    frames_done = 0;
    done_cnt    = 0;
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) done_cnt++;
      if (rst) begin
        mon_active  = 1'b0;
        b2b_pending = 1'b0;
        exp_q.delete();
      end else if (baud_tick) begin
        if (!mon_active) begin
          if (b2b_pending) begin
            chk("b2b_start", 32'(tx), 0);
            b2b_pending = 1'b0;
          end
          if (tx === 1'b0) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_start", 32'(tx), 1);
            end else begin
              e = exp_q.pop_front();
              for (int i = 0; i < 16; i++) mon_bits[i] = 1'b1;
              mon_bits[0] = 1'b0;
              for (int i = 0; i < 8; i++) mon_bits[i+1] = e.data[i];
              p = 9;
              if (e.par == 2'b01 || e.par == 2'b10) begin
                mon_bits[p] = e.exp_par;
                p++;
              end
              p++;
              if (e.stop2) p++;
              mon_len    = p;
              mon_idx    = 1;
              mon_active = 1'b1;
              chk("tx_done_at_start", 32'(tx_done), 0);
            end
          end
        end else begin
          chk("frame_bit", 32'(tx), 32'(mon_bits[mon_idx]));
          chk("tx_done", 32'(tx_done), 32'(mon_idx == mon_len - 1));
          mon_idx++;
          if (mon_idx == mon_len) begin
            mon_active  = 1'b0;
            frames_done++;
            b2b_pending = (exp_q.size() > 0);
          end
        end
      end
      if (tick_en) begin
        div       = (div == TICK_DIV - 1) ? 0 : div + 1;
        baud_tick = (div == 0);
      end else begin
        baud_tick = 1'b0;
      end
    end
  end

  task automatic push_word(input vec_t e);
    s_data  = e.data;
    s_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((mon_active || exp_q.size() != 0 || busy === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, %0d frames still expected (required 0)",
               name, n, exp_q.size());
    end
  endtask

  vec_t tbl[7];

  initial begin
    int         model;
    int         n;
    logic [6:0] exp5;
    vec_t       w;

    rst = 1'b1; tick_en = 1'b0; s_valid = 1'b0; s_data = '0; par_mode = 2'b00; stop2 = 1'b0;
    baud_tick5 = 1'b0; s_valid5 = 1'b0; s_data5 = '0;

    tbl[0] = '{8'h55, 2'b00, 1'b0, 1'b0};
    tbl[1] = '{8'h07, 2'b01, 1'b0, 1'b1};
    tbl[2] = '{8'h07, 2'b10, 1'b0, 1'b0};
    tbl[3] = '{8'hA3, 2'b01, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 2'b10, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 2'b11, 1'b1, 1'b0};
    tbl[6] = '{8'h3C, 2'b10, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_done", 32'(tx_done), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_tx5", 32'(tx5), 1);
    rst = 1'b0;
    @(negedge clk);

    // Five-bit payload, ticks stepped by hand.
    exp5     = 7'b1100110;
    s_data5  = 5'h13;
    s_valid5 = 1'b1;
    @(negedge clk);
    s_valid5 = 1'b0;
    @(negedge clk);
    chk("busy5", 32'(busy5), 1);
    chk("level5_popped", 32'(fifo_level5), 0);
    for (int k = 0; k < 7; k++) begin
      baud_tick5 = 1'b1;
      @(negedge clk);
      baud_tick5 = 1'b0;
      chk("tx5_bit", 32'(tx5), 32'(exp5[k]));
      chk("tx_done5", 32'(tx_done5), 32'(k == 6));
      @(negedge clk);
      chk("tx5_hold", 32'(tx5), 32'(exp5[k]));
    end
    baud_tick5 = 1'b1;
    @(negedge clk);
    baud_tick5 = 1'b0;
    chk("tx5_after", 32'(tx5), 1);
    chk("busy5_after", 32'(busy5), 0);
    chk("s_ready5", 32'(s_ready5), 1);

    // Table-driven frame formats; format inputs are flipped mid-frame.
    tick_en = 1'b1;
    for (int v = 0; v < 7; v++) begin
      par_mode = tbl[v].par;
      stop2    = tbl[v].stop2;
      push_word(tbl[v]);
      wait_busy("busy_tbl");
      par_mode = ~par_mode;
      stop2    = ~stop2;
      wait_idle(300, "frame_tbl");
      par_mode = 2'b00;
      stop2    = 1'b0;
    end

    // Fill to the limit while the transmitter is stalled in the start state.
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    w = '{8'hE1, 2'b00, 1'b0, 1'b0};
    push_word(w);
    wait_busy("busy_lvl");
    model = 0;
    for (int i = 0; i < 17; i++) begin
      w       = '{8'h10 + 8'(i), 2'b00, 1'b0, 1'b0};
      s_data  = w.data;
      s_valid = 1'b1;
      chk("s_ready_fill", 32'(s_ready), 32'(model < 16));
      if (model < 16) begin
        exp_q.push_back(w);
        model++;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("level_full", 32'(fifo_level), 16);
    chk("s_ready_full", 32'(s_ready), 0);
    tick_en = 1'b1;
    wait_idle(2000, "drain_lvl");
    chk("level_drained", 32'(fifo_level), 0);

    // Push coinciding with a pop at level 3, then back-to-back frames.
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    w = '{8'hC3, 2'b00, 1'b0, 1'b0}; push_word(w);
    wait_busy("busy_pp");
    w = '{8'h5A, 2'b00, 1'b0, 1'b0}; push_word(w);
    w = '{8'h01, 2'b00, 1'b0, 1'b0}; push_word(w);
    w = '{8'hFE, 2'b00, 1'b0, 1'b0}; push_word(w);
    chk("level3", 32'(fifo_level), 3);
    tick_en = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_slot", 32'(busy), 0);
    chk("level_pre_pp", 32'(fifo_level), 3);
    w = '{8'h96, 2'b00, 1'b0, 1'b0}; push_word(w);
    chk("level_pushpop", 32'(fifo_level), 3);
    wait_idle(800, "drain_pp");

    // Reset in the middle of data bit 4.
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    w = '{8'h0F, 2'b00, 1'b0, 1'b0}; push_word(w);
    wait_busy("busy_rst");
    w = '{8'hAA, 2'b00, 1'b0, 1'b0}; push_word(w);
    tick_en = 1'b1;
    n = 0;
    while (!(mon_active && mon_idx == 6) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit4", 32'(mon_idx), 6);
    chk("tx_bit4_low", 32'(tx), 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_s_ready", 32'(s_ready), 1);
    chk("mid_rst_tx_done", 32'(tx_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) n++;
    end
    chk("no_resume", 32'(n), 0);

    chk("done_pulses", 32'(done_cnt), 32'(frames_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo_cfg.md
UART_TX_FIFO_CFG -- requirements
Module: uart_tx_fifo_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit buffer entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port baud_tick  input  1  one-clk pulse per bit period; 1x bit rate.
REQ-006 SHALL have port s_valid  input  1  write request for s_data.
REQ-007 SHALL have port s_ready  output  1  high when FIFO not full.
REQ-008 SHALL have port s_data  input  DATA_BITS  payload word.
REQ-009 SHALL have port par_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-010 SHALL have port stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress (state not IDLE).
REQ-013 SHALL have port tx_done  output  1  one-clk pulse when a frame's final stop bit is driven.
REQ-014 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL accept a word when s_valid and s_ready are both high on a clk edge; s_data ignored otherwise.
REQ-016 SHALL hold words in a FIFO_DEPTH-entry FIFO, first-in first-out, with wrap-around pointers.
REQ-017 SHALL drive s_ready low exactly when fifo_level equals FIFO_DEPTH.
REQ-018 SHALL, on a simultaneous push and pop, leave fifo_level unchanged and lose no data; a push when full is ignored.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: tx=1; when FIFO non-empty, pop one word and latch it, par_mode and stop2 in the same cycle; go START.
REQ-021 START: on baud_tick drive tx=0; go DATA; bit counter cleared.
REQ-022 DATA: on each baud_tick drive the next payload bit, LSB first; after bit DATA_BITS-1 go PARITY if the latched mode is even/odd, else STOP.
REQ-023 PARITY: on baud_tick drive the XOR of payload bits (even) or its inverse (odd); go STOP.
REQ-024 STOP: on each baud_tick drive tx=1; after 1 (stop2=0) or 2 (stop2=1) such ticks, pulse tx_done and go IDLE in the same edge.
REQ-025 SHALL hold tx unchanged between baud_ticks; ticks seen in IDLE have no effect.
REQ-026 SHALL not start a new frame's start bit earlier than the baud_tick after the last stop tick (minimum one stop period).
REQ-027 SHALL ignore par_mode/stop2 changes mid-frame; they apply from the next pop.
REQ-028 SHALL allow back-to-back frames with no idle gap beyond the stop period when the FIFO is non-empty.

Reset
REQ-029 On rst: tx=1, busy=0, tx_done=0, s_ready=1, fifo_level=0, state IDLE, pointers and counters zero; FIFO contents discarded.
REQ-030 Reset asserted mid-frame SHALL force tx=1 within the same clk; no partial-frame resumption after release.

Structure
REQ-031 State enum and parity-mode encoding SHALL live in shared package uart_pkg.
REQ-032 FIFO SHALL be sub-module uart_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level).

Verification
REQ-033 DATA_BITS=8, none, stop2=0, push 0x55 -> tx low 1 period, bits 1,0,1,0,1,0,1,0, high 1 period; one tx_done pulse.
REQ-034 par_mode=01, push 0x07 -> parity bit 1; par_mode=10, push 0x07 -> parity bit 0; stop2=1 -> two high periods before next start.
REQ-035 Push 17 words at DEPTH=16 with no ticks -> s_ready low after 16, 17th not accepted, fifo_level=16; words emitted in order.
REQ-036 Push while popping at level 3 -> level stays 3; three queued frames emitted back-to-back, one stop period apart.
REQ-037 Assert rst during DATA bit 4 -> tx=1 immediately, busy=0, level=0; after release no frame until new push.
REQ-038 DATA_BITS=5, push 5'h13 -> exactly 5 data bits 1,1,0,0,1 then stop.
